bp_be_fe_queue_rolly: RTL and testbench
=======================================

BP_BE_FE_QUEUE_ROLLY -- requirements
Module: bp_be_fe_queue_rolly

Interface
REQ-001 SHALL have parameter bp_params_p, e_bp_inv_cfg, processor config; sets width fe_queue_width_lp.
REQ-002 SHALL have parameter els_p, 8, entry count; power of two, >=2.
REQ-003 SHALL have clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have reset_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have fe_queue_i  input  fe_queue_width_lp  FE packet to enqueue.
REQ-006 SHALL have fe_queue_v_i  input  1  enqueue valid.
REQ-007 SHALL have fe_queue_ready_o  output  1  space available; enqueue occurs on v_i & ready_o.
REQ-008 SHALL have fe_queue_o  output  fe_queue_width_lp  packet at speculative read pointer.
REQ-009 SHALL have fe_queue_v_o  output  1  fe_queue_o valid.
REQ-010 SHALL have fe_queue_yumi_i  input  1  BE consumes fe_queue_o; legal only when v_o=1.
REQ-011 SHALL have fe_queue_clr_i  input  1  discard all entries.
REQ-012 SHALL have fe_queue_deq_i  input  1  commit (free) oldest consumed entry.
REQ-013 SHALL have fe_queue_roll_i  input  1  rewind read pointer to oldest uncommitted entry.

Function
REQ-014 SHALL keep wptr, rptr, cptr, each $clog2(els_p)+1 bits (wrap bit), with cptr <= rptr <= wptr in modular order.
REQ-015 SHALL assert fe_queue_ready_o iff (wptr - cptr) mod 2*els_p < els_p; uncommitted entries are never overwritten.
REQ-016 SHALL assert fe_queue_v_o iff rptr != wptr and fe_queue_clr_i=0; fe_queue_o = mem[rptr index].
REQ-017 SHALL write fe_queue_i to mem[wptr index] and increment wptr on accepted enqueue; entry readable the next cycle (1-cycle latency).
REQ-018 SHALL increment rptr on yumi; cptr on deq; pointers wrap at 2*els_p.
REQ-019 SHALL give roll priority over yumi: roll sets rptr<=cptr (plus 1 if deq same cycle), yumi ignored.
REQ-020 SHALL give clr highest priority: wptr, rptr, cptr all <= current wptr; same-cycle enqueue, yumi, deq, roll discarded.
REQ-021 SHALL allow enqueue, yumi and deq in the same cycle, each applied independently.
REQ-022 SHALL treat deq with cptr==rptr, and yumi with v_o=0, as illegal; state unchanged and flagged by assertion.
REQ-023 SHALL retain commit/roll semantics across wrap-around with no bubble.

Reset
REQ-024 SHALL, on reset_i=1, set wptr=rptr=cptr=0 next edge; fe_queue_v_o=0, fe_queue_ready_o=1 during and after reset; mem contents undefined.
REQ-025 SHALL ignore all inputs while reset_i=1, including mid-operation; reset wins over clr.

Configuration
REQ-026 SHALL, with BP_BE_FE_QUEUE_BYPASS_EN defined, present fe_queue_i combinationally on fe_queue_o with fe_queue_v_o=1 when rptr==wptr, fe_queue_v_i=1, ready_o=1, clr=0; yumi that cycle advances wptr and rptr together (entry still written, held for commit).
REQ-027 SHALL, without BP_BE_FE_QUEUE_BYPASS_EN, never bypass; empty-to-valid latency exactly 1 cycle.

Structure
REQ-028 SHALL place the pointer-width localparam function and any queue-status typedef in bp_be_pkg; packet structs come from existing fe/be interface macros.
REQ-029 SHALL use one storage sub-module, bsg_mem_1r1w (els_p x fe_queue_width_lp, async read); pointer/control logic stays in this module.

Verification
REQ-030 SHALL cover fill: els_p=8, enqueue 8 packets 0x1..0x8 without deq -> ready_o=0 after 8th, 9th not accepted; yumi all 8 -> v_o=0, ready_o still 0.
REQ-031 SHALL cover roll: enqueue A,B,C; yumi A,B; deq once; roll -> next fe_queue_o=B, v_o=1; yumi B,C succeeds.
REQ-032 SHALL cover clr with simultaneous enqueue D, yumi, deq -> next cycle v_o=0, ready_o=1, D never appears.
REQ-033 SHALL cover wrap: 20 enqueue/yumi/deq triples at one per cycle -> outputs in order, no gaps, pointers wrap twice.
REQ-034 SHALL cover reset mid-stream with 5 entries held -> next cycle v_o=0, ready_o=1; post-reset packet 0xE readable after 1 cycle (0 cycles with BP_BE_FE_QUEUE_BYPASS_EN).
REQ-035 SHALL cover roll+deq+yumi same cycle with cptr=2, rptr=5 -> rptr=3, cptr=3, yumi ignored.

Source files
------------

// File: rtl/bp_be_pkg.sv
// Shared back-end types: processor configs, FE queue widths and status.
package bp_be_pkg;

    typedef enum logic [1:0] {
        e_bp_default_cfg,
        e_bp_inv_cfg,
        e_bp_multicore_cfg
    } bp_params_e;

    typedef struct packed {
        logic full;
        logic empty;
    } fe_queue_status_s;

    function automatic int fe_queue_width(bp_params_e cfg);
        case (cfg)
            e_bp_inv_cfg: return 32;
            default:      return 64;
        endcase
    endfunction

    // One extra wrap bit lets full and empty be told apart.
    function automatic int ptr_width(int els);
        return $clog2(els) + 1;
    endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write one-read register file with asynchronous read.
module bsg_mem_1r1w #(
    parameter int width_p = 32,
    parameter int els_p = 8,
    localparam int addr_w_lp = $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 w_v_i,
    input  logic [addr_w_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]   w_data_i,
    input  logic [addr_w_lp-1:0] r_addr_i,
    output logic [width_p-1:0]   r_data_o
);

    logic [width_p-1:0] mem_r [els_p];

    always_ff @(posedge clk_i) begin
        if (w_v_i) begin
            mem_r[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_fe_queue_rolly.sv
// FE->BE queue with speculative read, commit and roll-back pointers.
// Define BP_BE_FE_QUEUE_BYPASS_EN to forward an enqueue straight to an empty output.
module bp_be_fe_queue_rolly
    import bp_be_pkg::*;
#(
    parameter bp_params_e bp_params_p = e_bp_inv_cfg,
    parameter int els_p = 8,
    localparam int fe_queue_width_lp = fe_queue_width(bp_params_p)
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [fe_queue_width_lp-1:0] fe_queue_i,
    input  logic                         fe_queue_v_i,
    output logic                         fe_queue_ready_o,
    output logic [fe_queue_width_lp-1:0] fe_queue_o,
    output logic                         fe_queue_v_o,
    input  logic                         fe_queue_yumi_i,
    input  logic                         fe_queue_clr_i,
    input  logic                         fe_queue_deq_i,
    input  logic                         fe_queue_roll_i
);

    localparam int ptr_w_lp = ptr_width(els_p);
    localparam int idx_w_lp = ptr_w_lp - 1;

    logic [ptr_w_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [fe_queue_width_lp-1:0] rdata;
    fe_queue_status_s status;
    logic enq, yumi_ok, deq_ok;

    // Full when write is exactly one lap ahead of the commit pointer.
    assign status.full  = (wptr_r[idx_w_lp] != cptr_r[idx_w_lp])
                        && (wptr_r[idx_w_lp-1:0] == cptr_r[idx_w_lp-1:0]);
    assign status.empty = (rptr_r == wptr_r);

    assign fe_queue_ready_o = reset_i | ~status.full;
    assign enq = fe_queue_v_i & ~status.full & ~reset_i & ~fe_queue_clr_i;

`ifdef BP_BE_FE_QUEUE_BYPASS_EN
    logic byp;
    assign byp = status.empty & enq;
    assign fe_queue_v_o = ~reset_i & ~fe_queue_clr_i & (~status.empty | byp);
    assign fe_queue_o = byp ? fe_queue_i : rdata;
`else
    assign fe_queue_v_o = ~reset_i & ~fe_queue_clr_i & ~status.empty;
    assign fe_queue_o = rdata;
`endif

    assign yumi_ok = fe_queue_yumi_i & fe_queue_v_o;
    assign deq_ok = fe_queue_deq_i & (cptr_r != rptr_r)
                  & ~fe_queue_clr_i & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else if (fe_queue_clr_i) begin
            rptr_r <= wptr_r;
            cptr_r <= wptr_r;
        end else begin
            if (enq) begin
                wptr_r <= wptr_r + ptr_w_lp'(1);
            end
            if (fe_queue_roll_i) begin
                rptr_r <= cptr_r + ptr_w_lp'(deq_ok);
            end else if (yumi_ok) begin
                rptr_r <= rptr_r + ptr_w_lp'(1);
            end
            if (deq_ok) begin
                cptr_r <= cptr_r + ptr_w_lp'(1);
            end
        end
    end

    bsg_mem_1r1w #(
        .width_p(fe_queue_width_lp),
        .els_p  (els_p)
    ) mem (
        .clk_i   (clk_i),
        .w_v_i   (enq),
        .w_addr_i(wptr_r[idx_w_lp-1:0]),
        .w_data_i(fe_queue_i),
        .r_addr_i(rptr_r[idx_w_lp-1:0]),
        .r_data_o(rdata)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i && !fe_queue_clr_i) begin
            assert (!(fe_queue_yumi_i && !fe_queue_v_o))
                else $error("yumi with no valid entry");
            assert (!(fe_queue_deq_i && cptr_r == rptr_r))
                else $error("deq with nothing consumed");
        end
    end
`endif

endmodule

// File: tb/tb_bp_be_fe_queue_rolly.sv
// Scoreboard bench for the rolling FE queue.
module tb_bp_be_fe_queue_rolly;
    import bp_be_pkg::*;

    localparam int W = fe_queue_width(e_bp_inv_cfg);

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    logic [W-1:0] fe_queue_i = '0;
    logic fe_queue_v_i = 1'b0;
    logic fe_queue_ready_o;
    logic [W-1:0] fe_queue_o;
    logic fe_queue_v_o;
    logic fe_queue_yumi_i = 1'b0;
    logic fe_queue_clr_i = 1'b0;
    logic fe_queue_deq_i = 1'b0;
    logic fe_queue_roll_i = 1'b0;

    logic [W-1:0] exp_q[$];
    logic yumi_chk = 1'b0;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bp_be_fe_queue_rolly #(
        .bp_params_p(e_bp_inv_cfg),
        .els_p      (8)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .fe_queue_i      (fe_queue_i),
        .fe_queue_v_i    (fe_queue_v_i),
        .fe_queue_ready_o(fe_queue_ready_o),
        .fe_queue_o      (fe_queue_o),
        .fe_queue_v_o    (fe_queue_v_o),
        .fe_queue_yumi_i (fe_queue_yumi_i),
        .fe_queue_clr_i  (fe_queue_clr_i),
        .fe_queue_deq_i  (fe_queue_deq_i),
        .fe_queue_roll_i (fe_queue_roll_i)
    );

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge and hold for the whole cycle.
    task automatic step(input logic enq, input logic [W-1:0] d,
                        input logic yumi, input logic ychk,
                        input logic [W-1:0] ye, input logic deq,
                        input logic roll, input logic clr, input logic rst);
        @(posedge clk);
        #1;
        fe_queue_v_i = enq;
        fe_queue_i = d;
        fe_queue_yumi_i = yumi;
        yumi_chk = ychk;
        if (ychk) exp_q.push_back(ye);
        fe_queue_deq_i = deq;
        fe_queue_roll_i = roll;
        fe_queue_clr_i = clr;
        reset_i = rst;
    endtask

    task automatic idle();
        step(0, '0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [W-1:0] d);
        step(1, d, 0, 0, '0, 0, 0, 0, 0);
    endtask

    task automatic take(input logic [W-1:0] e);
        step(0, '0, 1, 1, e, 0, 0, 0, 0);
    endtask

    task automatic commit();
        step(0, '0, 0, 0, '0, 1, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (yumi_chk && fe_queue_yumi_i) begin
            if (!fe_queue_v_o) begin
                n_cmp++;
                n_err++;
                $display("FAIL yumi_valid: got v_o=0 want v_o=1");
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_underflow: got %0h want none",
                         fe_queue_o);
            end else begin
                chk("fe_queue_o", fe_queue_o, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        step(0, '0, 0, 0, '0, 0, 0, 0, 1);
        @(negedge clk);
        chk("rst_ready", fe_queue_ready_o, 1);
        chk("rst_v", fe_queue_v_o, 0);
        step(0, '0, 0, 0, '0, 0, 0, 0, 1);
        idle();
        @(negedge clk);
        chk("post_rst_ready", fe_queue_ready_o, 1);
        chk("post_rst_v", fe_queue_v_o, 0);

        // Fill to capacity, then drain speculatively without committing
        for (int i = 1; i <= 8; i++) push(W'(i));
        push(W'(9));
        @(negedge clk);
        chk("fill_ready", fe_queue_ready_o, 0);
        chk("fill_v", fe_queue_v_o, 1);
        for (int i = 1; i <= 8; i++) take(W'(i));
        idle();
        @(negedge clk);
        chk("drain_v", fe_queue_v_o, 0);
        chk("drain_ready", fe_queue_ready_o, 0);
        for (int i = 0; i < 8; i++) commit();
        idle();
        @(negedge clk);
        chk("commit_ready", fe_queue_ready_o, 1);

        // Roll back to the oldest uncommitted entry
        push(W'('hA1));
        push(W'('hB2));
        push(W'('hC3));
        take(W'('hA1));
        take(W'('hB2));
        commit();
        step(0, '0, 0, 0, '0, 0, 1, 0, 0);
        idle();
        @(negedge clk);
        chk("roll_o", fe_queue_o, W'('hB2));
        chk("roll_v", fe_queue_v_o, 1);
        take(W'('hB2));
        take(W'('hC3));
        commit();
        commit();
        idle();
        @(negedge clk);
        chk("roll_end_v", fe_queue_v_o, 0);

        // Clear with a simultaneous enqueue, yumi and deq
        push(W'('hE1));
        push(W'('hE2));
        take(W'('hE1));
        step(1, W'('hD0), 1, 0, '0, 1, 0, 1, 0);
        @(negedge clk);
        chk("clr_v_same", fe_queue_v_o, 0);
        idle();
        @(negedge clk);
        chk("clr_v", fe_queue_v_o, 0);
        chk("clr_ready", fe_queue_ready_o, 1);
        push(W'('hF0));
        take(W'('hF0));
        commit();

        // Streaming enqueue/yumi/deq triples across two pointer wraps
        for (int k = 0; k < 22; k++) begin
            step(k < 20, W'('h100 + k),
                 k >= 1 && k <= 20, k >= 1 && k <= 20, W'('h100 + k - 1),
                 k >= 2, 0, 0, 0);
        end
        idle();
        @(negedge clk);
        chk("wrap_v", fe_queue_v_o, 0);

        // cptr=2, rptr=5: roll+deq+yumi lands rptr=cptr=3
        for (int i = 0; i < 5; i++) push(W'('h200 + i));
        for (int i = 0; i < 3; i++) take(W'('h200 + i));
        step(0, '0, 1, 0, '0, 1, 1, 0, 0);
        idle();
        @(negedge clk);
        chk("rolldeq_o", fe_queue_o, W'('h201));
        chk("rolldeq_v", fe_queue_v_o, 1);
        for (int i = 1; i < 5; i++) take(W'('h200 + i));
        for (int i = 0; i < 4; i++) commit();
        idle();
        @(negedge clk);
        chk("rolldeq_end_v", fe_queue_v_o, 0);
        chk("rolldeq_end_ready", fe_queue_ready_o, 1);

        // Reset mid-stream with five entries held
        for (int i = 0; i < 5; i++) push(W'('h300 + i));
        take(W'('h300));
        take(W'('h301));
        step(1, W'('h3FF), 1, 0, '0, 1, 0, 1, 1);
        @(negedge clk);
        chk("midrst_v", fe_queue_v_o, 0);
        chk("midrst_ready", fe_queue_ready_o, 1);
        idle();
        @(negedge clk);
        chk("after_rst_v", fe_queue_v_o, 0);
        chk("after_rst_ready", fe_queue_ready_o, 1);
        push(W'('hE));
        @(negedge clk);
`ifdef BP_BE_FE_QUEUE_BYPASS_EN
        chk("byp_v", fe_queue_v_o, 1);
        chk("byp_o", fe_queue_o, W'('hE));
`else
        chk("nobyp_v", fe_queue_v_o, 0);
`endif
        take(W'('hE));
        commit();
        idle();
        @(negedge clk);
        chk("scoreboard_drained", W'(exp_q.size()), '0);
        chk("final_v", fe_queue_v_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
